// File: rtl/sum_stationary_stream.sv
// -----------------------------------------------------------------------------
// sum_stationary_stream
//
// Output-stationary NxN systolic matrix-multiply engine with a runtime inner
// dimension K (1..K_MAX). Operand beats (column k of A, row k of B) arrive
// under valid/ready. They pass through per-row/per-column skew registers into
// an NxN grid of multiply-accumulate PEs. After the last beat, the array is
// flushed with zeros for 2N-2 cycles. The C matrix is then drained one row
// per beat under valid/ready backpressure.
//
// Ports
//   clk_i        rising-edge clock
//   reset_i      asynchronous, active-high reset
//   k_len_i      inner dimension, sampled with the first accepted beat
//                (0 or >K_MAX means K_MAX)
//   in_valid_i   operand beat valid
//   in_ready_o   engine accepts an operand beat (IDLE/LOAD only)
//   a_i          column k of A, element r at a_i[r*DATA_WIDTH +: DATA_WIDTH]
//   b_i          row k of B, element c at b_i[c*DATA_WIDTH +: DATA_WIDTH]
//   out_valid_o  c_o holds a valid C row
//   out_ready_i  downstream accepts the row
//   c_o          C[out_row_o][c] at c_o[c*C_DATA_WIDTH +: C_DATA_WIDTH]
//   out_row_o    row index of c_o
//   out_last_o   high with row N-1
//   busy_o       engine not idle
//
// Configuration macro: SUM_STATIONARY_STREAM_SIGNED_EN
//   defined   -> two's complement operands, sign-extended products
//   undefined -> unsigned operands, zero-extended products (default)
//
// N must be at least 2.
// -----------------------------------------------------------------------------
module sum_stationary_stream #(
  parameter int DATA_WIDTH   = 8,
  parameter int N            = 4,
  parameter int K_MAX        = 16,
  parameter int C_DATA_WIDTH = 2*DATA_WIDTH + $clog2(K_MAX)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [$clog2(K_MAX+1)-1:0]   k_len_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [N*DATA_WIDTH-1:0]      a_i,
  input  logic [N*DATA_WIDTH-1:0]      b_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [N*C_DATA_WIDTH-1:0]    c_o,
  output logic [$clog2(N)-1:0]         out_row_o,
  output logic                         out_last_o,
  output logic                         busy_o
);

  localparam int DW        = DATA_WIDTH;
  localparam int CW        = C_DATA_WIDTH;
  localparam int KW        = $clog2(K_MAX+1);
  localparam int RW        = $clog2(N);
  localparam int FLUSH_LEN = 2*N - 2;
  localparam int FW        = $clog2(2*N);

  localparam logic [KW-1:0] K_MAX_L    = KW'(K_MAX);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // With N=1 there is nothing to flush, so loading goes straight to drain.
  localparam state_e POST_LOAD = (FLUSH_LEN == 0) ? ST_DRAIN : ST_FLUSH;

  // Product of one operand pair, extended to accumulator width.
  function automatic logic [CW-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
`ifdef SUM_STATIONARY_STREAM_SIGNED_EN
    p = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    mul_ext = {{(CW-2*DW){p[2*DW-1]}}, p};
`else
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    mul_ext = {{(CW-2*DW){1'b0}}, p};
`endif
  endfunction

  state_e          state_r, state_next_s;
  logic            in_ready_r, busy_r, out_valid_r, out_last_r;
  logic [RW-1:0]   row_r, row_next_s;
  logic [KW-1:0]   k_len_r, beat_cnt_r, beat_next_s, eff_k_s;
  logic [FW-1:0]   flush_cnt_r;

  logic            accept_s, flushing_s, advance_s, drain_hs_s, drain_last_s;

  logic [N*DW-1:0] a_edge_s, b_edge_s;
  logic [CW-1:0]   acc_r   [N][N];
  logic [DW-1:0]   west_r  [N][N];
  logic [DW-1:0]   north_r [N][N];
  logic [DW-1:0]   w_in_s  [N][N];
  logic [DW-1:0]   n_in_s  [N][N];
  logic [CW-1:0]   prod_s  [N][N];

  assign accept_s     = in_valid_i & in_ready_r;
  assign flushing_s   = (state_r == ST_FLUSH);
  assign advance_s    = accept_s | flushing_s;
  assign drain_hs_s   = (state_r == ST_DRAIN) & out_valid_r & out_ready_i;
  assign drain_last_s = drain_hs_s & (row_r == ROW_LAST);
  assign beat_next_s  = beat_cnt_r + KW'(1);
  assign eff_k_s      = ((k_len_i == {KW{1'b0}}) || (k_len_i > K_MAX_L)) ? K_MAX_L : k_len_i;

  // Next-state and drain row selection.
  always_comb begin
    state_next_s = state_r;
    row_next_s   = row_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (eff_k_s == KW'(1)) begin
            state_next_s = POST_LOAD;
          end else begin
            state_next_s = ST_LOAD;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s && (beat_next_s == k_len_r)) begin
          state_next_s = POST_LOAD;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_r == FLUSH_LAST) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_FLUSH;
        end
      end
      ST_DRAIN: begin
        if (drain_last_s) begin
          state_next_s = ST_IDLE;
          row_next_s   = {RW{1'b0}};
        end else if (drain_hs_s) begin
          row_next_s   = row_r + RW'(1);
        end else begin
          row_next_s   = row_r;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        row_next_s   = {RW{1'b0}};
      end
    endcase
  end

  // State register, registered handshake/status outputs and job counters.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      row_r       <= {RW{1'b0}};
      k_len_r     <= {KW{1'b0}};
      beat_cnt_r  <= {KW{1'b0}};
      flush_cnt_r <= {FW{1'b0}};
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == ST_IDLE) || (state_next_s == ST_LOAD);
      busy_r      <= (state_next_s != ST_IDLE);
      out_valid_r <= (state_next_s == ST_DRAIN);
      out_last_r  <= (state_next_s == ST_DRAIN) && (row_next_s == ROW_LAST);
      row_r       <= row_next_s;
      if ((state_r == ST_IDLE) && accept_s) begin
        k_len_r    <= eff_k_s;
        beat_cnt_r <= KW'(1);
      end else if ((state_r == ST_LOAD) && accept_s) begin
        beat_cnt_r <= beat_next_s;
      end
      flush_cnt_r <= flushing_s ? (flush_cnt_r + FW'(1)) : {FW{1'b0}};
    end
  end

  // Skew lines: row r of A and column c of B are delayed by r (resp. c)
  // advance steps so that matching k terms meet in PE(r,c).
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DW-1:0] a_src_s, b_src_s;
    assign a_src_s = flushing_s ? {DW{1'b0}} : a_i[i*DW +: DW];
    assign b_src_s = flushing_s ? {DW{1'b0}} : b_i[i*DW +: DW];
    if (i == 0) begin : g_direct
      assign a_edge_s[DW-1:0] = a_src_s;
      assign b_edge_s[DW-1:0] = b_src_s;
    end else begin : g_delay
      logic [DW-1:0] a_sk_r [i];
      logic [DW-1:0] b_sk_r [i];
      // Shift operands one skew stage per advance; cleared at end of job.
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          for (int j = 0; j < i; j++) begin
            a_sk_r[j] <= {DW{1'b0}};
            b_sk_r[j] <= {DW{1'b0}};
          end
        end else if (drain_last_s) begin
          for (int j = 0; j < i; j++) begin
            a_sk_r[j] <= {DW{1'b0}};
            b_sk_r[j] <= {DW{1'b0}};
          end
        end else if (advance_s) begin
          a_sk_r[0] <= a_src_s;
          b_sk_r[0] <= b_src_s;
          for (int j = 1; j < i; j++) begin
            a_sk_r[j] <= a_sk_r[j-1];
            b_sk_r[j] <= b_sk_r[j-1];
          end
        end
      end
      assign a_edge_s[i*DW +: DW] = a_sk_r[i-1];
      assign b_edge_s[i*DW +: DW] = b_sk_r[i-1];
    end
  end

  // PE operand routing: column 0 / row 0 take the skew outputs, the rest take
  // the neighbour's forwarded operand.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      w_in_s[r][0] = a_edge_s[r*DW +: DW];
      for (int c = 1; c < N; c++) begin
        w_in_s[r][c] = west_r[r][c-1];
      end
    end
    for (int c = 0; c < N; c++) begin
      n_in_s[0][c] = b_edge_s[c*DW +: DW];
      for (int r = 1; r < N; r++) begin
        n_in_s[r][c] = north_r[r-1][c];
      end
    end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        prod_s[r][c] = mul_ext(w_in_s[r][c], n_in_s[r][c]);
      end
    end
  end

  // PE grid: accumulate on advance; during drain the accumulator rows shift
  // up one per handshake so c_o always shows row 0 of the grid.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          acc_r[r][c]   <= {CW{1'b0}};
          west_r[r][c]  <= {DW{1'b0}};
          north_r[r][c] <= {DW{1'b0}};
        end
      end
    end else if (drain_last_s) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          acc_r[r][c]   <= {CW{1'b0}};
          west_r[r][c]  <= {DW{1'b0}};
          north_r[r][c] <= {DW{1'b0}};
        end
      end
    end else if (drain_hs_s) begin
      for (int c = 0; c < N; c++) begin
        for (int r = 0; r < N-1; r++) begin
          acc_r[r][c] <= acc_r[r+1][c];
        end
        acc_r[N-1][c] <= {CW{1'b0}};
      end
    end else if (advance_s) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          acc_r[r][c]   <= acc_r[r][c] + prod_s[r][c];
          west_r[r][c]  <= w_in_s[r][c];
          north_r[r][c] <= n_in_s[r][c];
        end
      end
    end
  end

  // Present the top accumulator row on c_o.
  always_comb begin
    c_o = {(N*CW){1'b0}};
    for (int c = 0; c < N; c++) begin
      c_o[c*CW +: CW] = acc_r[0][c];
    end
  end

  assign in_ready_o  = in_ready_r;
  assign out_valid_o = out_valid_r;
  assign out_row_o   = row_r;
  assign out_last_o  = out_last_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_sum_stationary_stream.sv
// -----------------------------------------------------------------------------
// Testbench for sum_stationary_stream (N=4, DATA_WIDTH=8, K_MAX=16).
// Expected C rows are pushed to a scoreboard queue as jobs are issued; a
// monitor compares c_o/out_row_o/out_last_o against the queue head on every
// cycle with out_valid_o high, popping on handshake.
// -----------------------------------------------------------------------------
module tb_sum_stationary_stream;

  localparam int DW    = 8;
  localparam int N     = 4;
  localparam int K_MAX = 16;
  localparam int CW    = 20;
  localparam int KW    = 5;

  logic            clk_i;
  logic            reset_i;
  logic [KW-1:0]   k_len_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [N*DW-1:0] a_i;
  logic [N*DW-1:0] b_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [N*CW-1:0] c_o;
  logic [1:0]      out_row_o;
  logic            out_last_o;
  logic            busy_o;

  sum_stationary_stream #(
    .DATA_WIDTH(DW),
    .N(N),
    .K_MAX(K_MAX)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .k_len_i(k_len_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .a_i(a_i),
    .b_i(b_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .c_o(c_o),
    .out_row_o(out_row_o),
    .out_last_o(out_last_o),
    .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [N*CW-1:0] c;
    logic [1:0]      row;
    logic            last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks    = 0;
  int   failures  = 0;
  int   stall_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [N*CW-1:0] row4(input int v0, input int v1, input int v2, input int v3);
    row4 = {CW'(v3), CW'(v2), CW'(v1), CW'(v0)};
  endfunction

  function automatic logic [N*DW-1:0] vec4(input int v0, input int v1, input int v2, input int v3);
    vec4 = {DW'(v3), DW'(v2), DW'(v1), DW'(v0)};
  endfunction

  task automatic push_job(input logic [N*CW-1:0] r0, input logic [N*CW-1:0] r1,
                          input logic [N*CW-1:0] r2, input logic [N*CW-1:0] r3);
    exp_q.push_back('{c: r0, row: 2'd0, last: 1'b0});
    exp_q.push_back('{c: r1, row: 2'd1, last: 1'b0});
    exp_q.push_back('{c: r2, row: 2'd2, last: 1'b0});
    exp_q.push_back('{c: r3, row: 2'd3, last: 1'b1});
  endtask

  task automatic push_case1();
    push_job(row4(1, 2, 3, 4), row4(5, 6, 7, 8), row4(9, 10, 11, 12), row4(13, 14, 15, 16));
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic offer(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
    logic got;
    got = 1'b0;
    in_valid_i = 1'b1;
    a_i = a;
    b_i = b;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    if (!got) chk("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_case1();
    k_len_i = KW'(4);
    for (int k = 0; k < 4; k++) begin
      offer(vec4(k == 0, k == 1, k == 2, k == 3), vec4(4*k+1, 4*k+2, 4*k+3, 4*k+4));
    end
  endtask

  // Wait until the engine is idle and every expected row has been seen.
  task automatic wait_drained();
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk_i);
      if (!busy_o && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 1'b0, 1'b1);
    chk("ready_after_drain", in_ready_o, 1'b1);
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk_i) begin
    if (!reset_i && out_valid_o) begin
      if (!out_ready_i) stall_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_row", {out_last_o, out_row_o, c_o}, 128'd0);
      end else begin
        mon_e = exp_q[0];
        chk("c_row", {out_last_o, out_row_o, c_o}, {mon_e.last, mon_e.row, mon_e.c});
        if (out_ready_i) mon_e = exp_q.pop_front();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    int viol;
    logic done;
    logic prev_last_hs;
    logic [CW-1:0] full_val;
    logic [CW-1:0] c4_val;

    reset_i     = 1'b1;
    k_len_i     = KW'(0);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    a_i         = '0;
    b_i         = '0;

    // Reset state
    #3;
    chk("reset_in_ready", in_ready_o, 1'b0);
    chk("reset_out_valid", out_valid_o, 1'b0);
    chk("reset_c", c_o, '0);
    chk("reset_row_last", {out_row_o, out_last_o}, 3'd0);
    chk("reset_busy", busy_o, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("ready_after_reset", in_ready_o, 1'b1);

    // Case 1: A = I, C = B, latency 6 edges
    out_ready_i = 1'b1;
    push_case1();
    send_case1();
    chk("ready_low_flush", in_ready_o, 1'b0);
    chk("busy_flush", busy_o, 1'b1);
    n = 0;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk_i);
      #1;
      n++;
      if (out_valid_o) break;
    end
    chk("valid_latency", n, 6);
    wait_drained();

    // Case 2: backpressure at row 2 for 5 cycles
    push_case1();
    send_case1();
    done = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk_i);
      #1;
      if (out_valid_o && out_row_o == 2'd2) begin
        done = 1'b1;
        break;
      end
    end
    chk("row2_seen", done, 1'b1);
    stall_cnt = 0;
    out_ready_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    out_ready_i = 1'b1;
    chk("stall_cycles", stall_cnt, 5);
    wait_drained();

    // Case 3: k_len=0 -> 16, full-scale operands, toggling valid
`ifdef SUM_STATIONARY_STREAM_SIGNED_EN
    full_val = CW'(16);
`else
    full_val = CW'(1040400);
`endif
    push_job(row4(full_val, full_val, full_val, full_val), row4(full_val, full_val, full_val, full_val),
             row4(full_val, full_val, full_val, full_val), row4(full_val, full_val, full_val, full_val));
    k_len_i = KW'(0);
    a_i = vec4(255, 255, 255, 255);
    b_i = vec4(255, 255, 255, 255);
    cnt = 0;
    viol = 0;
    done = 1'b0;
    for (int t = 0; t < 200; t++) begin
      in_valid_i = (t % 2 == 1);
      @(negedge clk_i);
      if (cnt == 16 && !busy_o) begin
        in_valid_i = 1'b0;
        done = 1'b1;
        break;
      end
      if (cnt == 16 && in_ready_o) viol++;
      if (in_valid_i && in_ready_o) cnt++;
      @(posedge clk_i);
      #1;
    end
    in_valid_i = 1'b0;
    chk("case3_done", done, 1'b1);
    chk("case3_beats", cnt, 16);
    chk("case3_ready_low", viol, 0);
    chk("case3_sb_empty", exp_q.size(), 0);
    @(posedge clk_i);
    #1;

    // Case 4: k_len=3, a=0xFF, b=0x02
`ifdef SUM_STATIONARY_STREAM_SIGNED_EN
    c4_val = 20'hFFFFA;
`else
    c4_val = CW'(1530);
`endif
    push_job(row4(c4_val, c4_val, c4_val, c4_val), row4(c4_val, c4_val, c4_val, c4_val),
             row4(c4_val, c4_val, c4_val, c4_val), row4(c4_val, c4_val, c4_val, c4_val));
    k_len_i = KW'(3);
    for (int k = 0; k < 3; k++) offer(vec4(255, 255, 255, 255), vec4(2, 2, 2, 2));
    wait_drained();

    // Case 5: reset mid-flush, then a clean rerun of case 1
    send_case1();
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    chk("case5_busy_before", busy_o, 1'b1);
    reset_i = 1'b1;
    #1;
    chk("case5_valid_reset", out_valid_o, 1'b0);
    chk("case5_busy_reset", busy_o, 1'b0);
    chk("case5_ready_reset", in_ready_o, 1'b0);
    chk("case5_c_reset", c_o, '0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    push_case1();
    send_case1();
    wait_drained();

    // Case 6: job B offered while job A drains
    push_case1();
    send_case1();
    k_len_i = KW'(2);
    in_valid_i = 1'b1;
    a_i = vec4(1, 1, 1, 1);
    b_i = vec4(1, 2, 3, 4);
    prev_last_hs = 1'b0;
    done = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        done = 1'b1;
        break;
      end
      prev_last_hs = out_valid_o && out_ready_i && out_last_o;
    end
    chk("case6_ready_seen", done, 1'b1);
    chk("case6_after_last_hs", prev_last_hs, 1'b1);
    chk("case6_a_drained", exp_q.size(), 0);
    push_job(row4(21, 42, 63, 84), row4(21, 42, 63, 84), row4(21, 42, 63, 84), row4(21, 42, 63, 84));
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    offer(vec4(2, 2, 2, 2), vec4(10, 20, 30, 40));
    wait_drained();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
